// File: rtl/pixel_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scan_gen
// Description : Generates a stream of (x, y) pixel positions covering a
//               margin-trimmed, strided region of an image, in raster or
//               serpentine order, with a valid/ready handshake and
//               row/frame boundary flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scan_gen #(
  parameter int X_MAX  = 640,
  parameter int Y_MAX  = 480,
  parameter int STEP_W = 3,
  localparam int XW = $clog2(X_MAX + 1),
  localparam int YW = $clog2(Y_MAX + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [XW-1:0]     width,
  input  logic [YW-1:0]     height,
  input  logic [XW-1:0]     margin,
  input  logic [STEP_W-1:0] step,
  input  logic              pos_ready,
  output logic              pos_valid,
  output logic [XW-1:0]     curr_x,
  output logic [YW-1:0]     curr_y,
  output logic              dir_x,
  output logic              row_first,
  output logic              row_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  // Internal arithmetic width: wide enough for 2*margin and for coord+step,
  // so bounds comparisons never wrap.
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int AW = ((MW > STEP_W) ? MW : STEP_W) + 1;
  localparam logic [AW-1:0] C_ONE = AW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] step_q, step_d;
  logic [AW-1:0] x_lo_q, x_lo_d;
  logic [AW-1:0] x_hi_q, x_hi_d;
  logic [AW-1:0] y_hi_q, y_hi_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          dir_q, dir_d;
  logic          row_first_q, row_first_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          w_run;
  logic          w_hs;
  logic [AW-1:0] w_x_a;
  logic [AW-1:0] w_y_a;
  logic [AW-1:0] w_marg;
  logic [AW-1:0] w_step_in;
  logic          w_cfg_bad;
  logic          w_row_end;
  logic          w_last_row;

  assign w_run     = (state_q == S_RUN);
  assign w_hs      = w_run & pos_ready;
  assign w_x_a     = AW'(x_q);
  assign w_y_a     = AW'(y_q);
  assign w_marg    = AW'(margin);
  assign w_step_in = (step == '0) ? C_ONE : AW'(step);
  assign w_cfg_bad = (AW'(width) <= (w_marg << 1)) || (AW'(height) <= (w_marg << 1));

  // A row ends when one more stride would leave the region in the current
  // traversal direction; no column count or division is needed.
  assign w_row_end  = dir_q ? (w_x_a < (x_lo_q + step_q))
                            : ((w_x_a + step_q) > x_hi_q);
  assign w_last_row = (w_y_a + step_q) > y_hi_q;

  assign pos_valid  = w_run;
  assign busy       = w_run;
  assign curr_x     = x_q;
  assign curr_y     = y_q;
  assign dir_x      = w_run & dir_q;
  assign row_first  = w_run & row_first_q;
  assign row_last   = w_run & w_row_end;
  assign frame_last = w_run & w_row_end & w_last_row;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      step_q      <= '0;
      x_lo_q      <= '0;
      x_hi_q      <= '0;
      y_hi_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= 1'b0;
      row_first_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      x_lo_q      <= x_lo_d;
      x_hi_q      <= x_hi_d;
      y_hi_q      <= y_hi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      row_first_q <= row_first_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Next-state: config capture on start, position advance on handshake.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    step_d      = step_q;
    x_lo_d      = x_lo_q;
    x_hi_d      = x_hi_q;
    y_hi_d      = y_hi_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    row_first_d = row_first_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with abort is dropped entirely
        if (start && !abort) begin
          if (w_cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = S_RUN;
            mode_d      = mode;
            step_d      = w_step_in;
            x_lo_d      = w_marg;
            x_hi_d      = AW'(width) - C_ONE - w_marg;
            y_hi_d      = AW'(height) - C_ONE - w_marg;
            x_d         = XW'(w_marg);
            y_d         = YW'(w_marg);
            dir_d       = 1'b0;
            row_first_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_hs) begin
          if (w_row_end && w_last_row) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (w_row_end) begin
            y_d         = YW'(w_y_a + step_q);
            row_first_d = 1'b1;
            if (mode_q) begin
              dir_d = ~dir_q;
            end else begin
              x_d = XW'(x_lo_q);
            end
          end else begin
            row_first_d = 1'b0;
            x_d         = dir_q ? XW'(w_x_a - step_q) : XW'(w_x_a + step_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scan_gen
// Description : Scoreboard bench for pixel_scan_gen. Stimulus pushes the
//               expected position list built from column/row sets; a monitor
//               pops and compares on every accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scan_gen;

  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [XW-1:0] width = '0;
  logic [YW-1:0] height = '0;
  logic [XW-1:0] margin = '0;
  logic [2:0]    step = '0;
  logic          pos_ready = 1'b0;
  logic          pos_valid, dir_x, row_first, row_last, frame_last, busy, done, cfg_err;
  logic [XW-1:0] curr_x;
  logic [YW-1:0] curr_y;

  pixel_scan_gen #(.X_MAX(640), .Y_MAX(480), .STEP_W(3)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode(mode),
    .width(width), .height(height), .margin(margin), .step(step),
    .pos_ready(pos_ready), .pos_valid(pos_valid), .curr_x(curr_x),
    .curr_y(curr_y), .dir_x(dir_x), .row_first(row_first),
    .row_last(row_last), .frame_last(frame_last), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit dir;
    bit rf;
    bit rl;
    bit fl;
  } pos_t;

  pos_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   sb_popped = 0;
  int   n_expected = 0;
  bit   expect_done = 1'b0;
  bit   hold_pend = 1'b0;
  pos_t hold_val;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic string fmt(input pos_t p);
    return $sformatf("x=%0d y=%0d dir=%0d rf=%0d rl=%0d fl=%0d", p.x, p.y, p.dir, p.rf, p.rl, p.fl);
  endfunction

  task automatic chk_pos(input string name, input pos_t a, input pos_t e);
    n_cmp++;
    if (!(a.x == e.x && a.y == e.y && a.dir == e.dir && a.rf == e.rf && a.rl == e.rl && a.fl == e.fl)) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %s expected %s", name, sb_popped, fmt(a), fmt(e));
    end
  endtask

  // Reference: enumerate column set C and row set R, then walk rows,
  // reversing odd rows in serpentine mode.
  task automatic push_model(input bit md, input int w, input int h, input int m, input int s);
    int   xs[$];
    int   ys[$];
    int   st;
    pos_t e;
    st = (s == 0) ? 1 : s;
    for (int x = m; x <= w - 1 - m; x += st) xs.push_back(x);
    for (int y = m; y <= h - 1 - m; y += st) ys.push_back(y);
    n_expected = xs.size() * ys.size();
    for (int j = 0; j < ys.size(); j++) begin
      for (int k = 0; k < xs.size(); k++) begin
        e.dir = md && (j % 2 == 1);
        e.x   = e.dir ? xs[xs.size() - 1 - k] : xs[k];
        e.y   = ys[j];
        e.rf  = (k == 0);
        e.rl  = (k == xs.size() - 1);
        e.fl  = e.rl && (j == ys.size() - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pos_t a;
    pos_t e;
    if (!n_rst) begin
      hold_pend   = 1'b0;
      expect_done = 1'b0;
    end else begin
      a.x = int'(curr_x);  a.y = int'(curr_y);  a.dir = dir_x;
      a.rf = row_first;    a.rl = row_last;     a.fl = frame_last;
      if (expect_done) begin
        chk("done_pulse", int'({done, pos_valid, busy}), 4);
        expect_done = 1'b0;
      end else if (done) begin
        chk("done_spurious", int'(done), 0);
      end
      if (hold_pend && pos_valid) chk_pos("hold", a, hold_val);
      hold_pend = 1'b0;
      if (pos_valid && !pos_ready && !abort) begin
        hold_pend = 1'b1;
        hold_val  = a;
      end
      if (pos_valid && pos_ready && !abort) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pos: got %s expected none", fmt(a));
        end else begin
          e = sb_q.pop_front();
          chk_pos("pos", a, e);
          sb_popped++;
          if (e.fl) expect_done = 1'b1;
        end
      end
    end
  end

  task automatic scramble();
    mode   = 1'($urandom_range(0, 1));
    width  = XW'($urandom_range(0, 1023));
    height = YW'($urandom_range(0, 511));
    margin = XW'($urandom_range(0, 1023));
    step   = 3'($urandom_range(0, 7));
  endtask

  function automatic bit ready_pat(input int rm, input int c);
    if (rm == 0) return 1'b1;
    if (rm == 1) return (c % 4 == 0) || (c % 4 == 3);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic drive_cfg(input bit md, input int w, input int h, input int m, input int s);
    mode = md; width = XW'(w); height = YW'(h); margin = XW'(m); step = 3'(s);
  endtask

  task automatic start_scan(input bit md, input int w, input int h, input int m, input int s);
    push_model(md, w, h, m, s);
    sb_popped = 0;
    @(posedge clk); #1;
    start = 1'b1;
    drive_cfg(md, w, h, m, s);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("first_valid", int'({pos_valid, busy, cfg_err}), 6);
  endtask

  task automatic illegal_cfg(input bit md, input int w, input int h, input int m, input int s);
    @(posedge clk); #1;
    start = 1'b1;
    drive_cfg(md, w, h, m, s);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("cfg_err_pulse", int'({cfg_err, busy, pos_valid, done}), 8);
    @(negedge clk);
    chk("cfg_err_clear", int'({cfg_err, busy, pos_valid, done}), 0);
  endtask

  task automatic run_scan(input bit md, input int w, input int h, input int m, input int s, input int rm);
    int cyc;
    if (!(w > 2 * m && h > 2 * m)) begin
      illegal_cfg(md, w, h, m, s);
      return;
    end
    pos_ready = ready_pat(rm, 0);
    start_scan(md, w, h, m, s);
    cyc = 1;
    while ((sb_q.size() != 0 || expect_done) && cyc < 4000) begin
      @(posedge clk); #1;
      pos_ready = ready_pat(rm, cyc);
      cyc++;
    end
    if (cyc >= 4000) begin
      chk("scan_timeout", sb_q.size(), 0);
      sb_q.delete();
      expect_done = 1'b0;
    end else begin
      chk("accept_count", sb_popped, n_expected);
    end
    @(negedge clk);
    chk("idle_after", int'({pos_valid, busy}), 0);
  endtask

  initial begin
    bit act;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({pos_valid, curr_x, curr_y, dir_x, row_first, row_last,
                             frame_last, busy, done, cfg_err}), 0);
    n_rst = 1'b1;

    run_scan(1'b0, 6, 4, 1, 1, 0);   // raster 4x2
    run_scan(1'b1, 6, 5, 0, 2, 0);   // serpentine stride 2
    run_scan(1'b0, 6, 4, 1, 1, 1);   // backpressure 1,0,0,1
    run_scan(1'b0, 4, 6, 2, 1, 0);   // width <= 2*margin

    // Abort on the third handshake cycle
    pos_ready = 1'b1;
    start_scan(1'b0, 6, 4, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_accepted", sb_popped, 2);
    chk("abort_idle", int'({pos_valid, busy}), 0);
    sb_q.delete();
    repeat (4) @(negedge clk);
    run_scan(1'b0, 6, 4, 1, 1, 0);

    // Reset in the middle of a scan
    pos_ready = 1'b1;
    start_scan(1'b1, 6, 5, 0, 2);
    @(posedge clk); #1;
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk("reset_midscan", int'({pos_valid, curr_x, curr_y, dir_x, row_first, row_last,
                               frame_last, busy, done, cfg_err}), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      act = act | pos_valid | busy | done;
    end
    chk("reset_quiet", int'(act), 0);

    // Boundary shapes
    run_scan(1'b1, 3, 7, 1, 1, 2);   // single column
    run_scan(1'b0, 9, 3, 1, 1, 2);   // single row
    run_scan(1'b1, 5, 3, 1, 0, 1);   // step 0 acts as 1
    run_scan(1'b1, 640, 4, 0, 7, 2); // full-width rows
    run_scan(1'b1, 7, 7, 3, 2, 0);   // 1x1 region

    // start together with abort in IDLE
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    drive_cfg(1'b0, 6, 4, 1, 1);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", int'({busy, pos_valid, cfg_err}), 0);

    for (int i = 0; i < 16; i++) begin
      run_scan(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)),
               int'($urandom_range(1, 16)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
